islip_voq_sched: RTL and testbench
==================================

# islip_voq_sched

Request/consume-side controller for the crossbar iSLIP arbiter. It keeps per-(input, output) virtual-output-queue packet counts and builds the request matrix from them. It presents that matrix to the arbiter over a valid/ready handshake, takes back the grant matrix, and launches one crossbar transfer per granted input. It then waits for all launched transfers to complete before starting the next arbitration round.

## Interface
Parameters:
- PORTS, 4, number of switch ports (inputs = outputs = PORTS)
- PORTS_L2, $clog2(PORTS), output index width
- CNT_WIDTH, 8, per-VOQ packet counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- voq_enq  in  PORTS*PORTS  one-cycle pulse; bit i*PORTS+o = one packet enqueued at input i for output o
- tx_rdy  in  PORTS  output o can accept a packet
- arb_valid_out  out  1  request matrix valid toward arbiter
- arb_ready_in  in  1  arbiter accepts request
- req_vect  out  PORTS*PORTS  request matrix; row i (bits i*PORTS+:PORTS) = outputs input i requests
- arb_valid_in  in  1  grant matrix valid from arbiter
- arb_ready_out  out  1  controller accepts grant
- grant_vect  in  PORTS*PORTS  grant matrix; row i = output granted to input i (one-hot or zero)
- xfer_start  out  PORTS  one-cycle pulse per input launching a transfer
- xfer_sel  out  PORTS*PORTS_L2  field i = output index for input i; valid while input i's transfer is pending
- xfer_done  in  PORTS  one-cycle pulse: input i's transfer finished
- busy  out  1  state != IDLE
- voq_ovf  out  1  sticky: an enqueue hit a saturated counter
- grant_err  out  1  sticky: grant row with >1 bit set, or a grant bit outside the latched request

## Operation
- Counters cnt[i][o]:
  - +1 on voq_enq, saturating at 2^CNT_WIDTH-1.
  - An enqueue while saturated sets voq_ovf.
  - -1 on the ISSUE cycle for each granted pair.
  - Enqueue and dequeue of the same pair in the same cycle leaves the count unchanged.
  - Counters never go below 0.
- Live request: req[i][o] = (cnt[i][o] != 0) & tx_rdy[o].
- States: IDLE, REQ, WAIT, ISSUE, XFER.
  - IDLE: if any live request bit is set, latch the live matrix into req_vect, go to REQ. Otherwise stay.
  - REQ: arb_valid_out=1. req_vect is held. On arb_ready_in go to WAIT.
  - WAIT: arb_ready_out=1. On arb_valid_in, latch grant_vect & req_vect, keeping the lowest set bit per row.
    - If any row had >1 bit, or any grant bit was outside req_vect, set grant_err.
    - If the sanitized grant is all zero, go to IDLE. Otherwise go to ISSUE.
  - ISSUE (1 cycle): xfer_start[i]=1 for each granted row. xfer_sel[i] = binary index of that row's grant. Decrement the granted counters. pending = granted rows. Go to XFER.
  - XFER: xfer_done[i] clears pending[i]. Done pulses for non-pending inputs are ignored. When pending becomes 0 (including in the cycle of the last done), go to IDLE next cycle.
- req_vect, xfer_sel and the latched grant hold their values until overwritten. req_vect is cleared to 0 on return to IDLE.
- rst at any point: every state, counter, pending bit and sticky flag returns to its reset value on the next edge.

## Timing
- Reset values: arb_valid_out=0, arb_ready_out=0, req_vect=0, xfer_start=0, xfer_sel=0, busy=0, voq_ovf=0, grant_err=0, all counters 0.
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.
- First enqueue to arb_valid_out: enq at edge t, count visible at t+1, REQ entered at t+2.
- Best-case round: IDLE, REQ, WAIT, ISSUE, then XFER with done at its first cycle = 5 cycles. The next IDLE is at cycle 6.
- Handshakes:
  - arb_valid_out stays high until arb_ready_in, with req_vect stable throughout.
  - arb_ready_out is high during every WAIT cycle; the grant is captured in the first cycle arb_valid_in=1.
- xfer_done in the same cycle as ISSUE is ignored, because pending is not yet set.
- tx_rdy changes after a request matrix is latched do not alter the latched req_vect.

## Test plan
- Single pair: PORTS=4, pulse voq_enq bit 6 (in1→out2), tx_rdy=4'hF, arbiter grants row1=4'b0100 → req_vect=16'h0040, xfer_start=4'b0010, xfer_sel field1=2, cnt[1][2]=0 after ISSUE, busy falls after xfer_done[1], and no second request follows.
- Contention: enq in0→out3 and in1→out3, grant row0 only → xfer_start=4'b0001. Next round req_vect=16'h0080, and row1 is granted.
- Backpressure: enq in2→out1 with tx_rdy[1]=0 → stays IDLE, arb_valid_out=0. Raising tx_rdy[1] gives arb_valid_out=1 two cycles later.
- Saturation: 256 enq pulses on in0→out0, CNT_WIDTH=8 → count=255, voq_ovf=1. After one grant, count=254.
- Bad and zero grant: a grant row 0x3 or a bit outside the request → lowest legal bit used and grant_err=1. An all-zero grant → returns to IDLE with counters unchanged, and the next round re-requests.
- Reset mid-XFER: assert rst with 2 transfers pending → next cycle busy=0, xfer_sel=0, counters 0, and later xfer_done pulses are ignored.

Source files
------------

// File: rtl/islip_voq_sched.sv
// islip_voq_sched
//   Request/consume-side controller for the crossbar iSLIP arbiter.
//   It keeps one packet counter per (input, output) virtual output queue.
//   Each round it snapshots the live request matrix and offers it to the
//   arbiter. It then sanitises the returned grant and launches one transfer
//   per granted input. The next round starts only after every launched
//   transfer has reported done.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   voq_enq        per-pair enqueue pulse, bit i*PORTS+o = input i -> output o
//   tx_rdy         per-output readiness; gates the live request
//   arb_valid_out  request matrix offered (REQ state)
//   arb_ready_in   arbiter took the request
//   req_vect       latched request matrix, row i = bits i*PORTS +: PORTS
//   arb_valid_in   grant matrix offered by arbiter
//   arb_ready_out  controller can take a grant (WAIT state)
//   grant_vect     grant matrix from arbiter, row per input
//   xfer_start     one-cycle launch pulse per granted input (ISSUE state)
//   xfer_sel       field i = output index for input i's transfer
//   xfer_done      per-input transfer-finished pulse
//   busy           controller is not idle
//   voq_ovf        sticky: enqueue into a saturated counter
//   grant_err      sticky: malformed grant row or grant outside the request
//   state_dbg      current FSM state, for observation only
//
// Handshake rule (both directions): a transfer happens on a rising clk edge
// where valid and ready are both high. The request side holds valid and
// req_vect stable until that edge. The grant side holds ready high for the
// whole WAIT state and captures on the first cycle valid is seen.
module islip_voq_sched #(
  parameter int PORTS     = 4,
  parameter int PORTS_L2  = $clog2(PORTS),
  parameter int CNT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*PORTS-1:0]      voq_enq,
  input  logic [PORTS-1:0]            tx_rdy,
  output logic                        arb_valid_out,
  input  logic                        arb_ready_in,
  output logic [PORTS*PORTS-1:0]      req_vect,
  input  logic                        arb_valid_in,
  output logic                        arb_ready_out,
  input  logic [PORTS*PORTS-1:0]      grant_vect,
  output logic [PORTS-1:0]            xfer_start,
  output logic [PORTS*PORTS_L2-1:0]   xfer_sel,
  input  logic [PORTS-1:0]            xfer_done,
  output logic                        busy,
  output logic                        voq_ovf,
  output logic                        grant_err,
  output logic [2:0]                  state_dbg
);

  localparam int N = PORTS * PORTS;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_XFER  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0][CNT_WIDTH-1:0] cnt;
  logic [N-1:0]                live_req;
  logic [N-1:0]                grant_q;
  logic [N-1:0]                grant_clean;
  logic [N-1:0]                dec_vec;
  logic                        grant_bad;
  logic [PORTS-1:0]            pending;
  logic [PORTS-1:0]            pending_left;
  logic [PORTS-1:0]            row_any;
  logic [PORTS*PORTS_L2-1:0]   sel_d;
  logic [PORTS-1:0]            row_raw, row_req, row_m, row_low;

  // Live request: queue non-empty and its output able to accept.
  always_comb begin
    live_req = '0;
    for (int i = 0; i < PORTS; i++) begin
      for (int o = 0; o < PORTS; o++) begin
        live_req[i*PORTS+o] = (cnt[i*PORTS+o] != '0) & tx_rdy[o];
      end
    end
  end

  // Grant sanitising: mask by the latched request, keep the lowest set bit
  // per row, flag any row that was not one-hot-or-zero or that granted an
  // unrequested pair, and encode the surviving bit as an output index.
  always_comb begin
    grant_clean = '0;
    grant_bad   = 1'b0;
    sel_d       = xfer_sel;
    row_raw     = '0;
    row_req     = '0;
    row_m       = '0;
    row_low     = '0;
    for (int i = 0; i < PORTS; i++) begin
      row_raw = grant_vect[i*PORTS +: PORTS];
      row_req = req_vect[i*PORTS +: PORTS];
      row_m   = row_raw & row_req;
      row_low = row_m & (~row_m + PORTS'(1));
      grant_clean[i*PORTS +: PORTS] = row_low;
      if ((row_raw & (row_raw - PORTS'(1))) != '0) grant_bad = 1'b1;
      if ((row_raw & ~row_req) != '0) grant_bad = 1'b1;
      for (int o = 0; o < PORTS; o++) begin
        if (row_low[o]) sel_d[i*PORTS_L2 +: PORTS_L2] = PORTS_L2'(o);
      end
    end
  end

  always_comb begin
    row_any = '0;
    for (int i = 0; i < PORTS; i++) begin
      row_any[i] = |grant_q[i*PORTS +: PORTS];
    end
  end

  assign dec_vec      = (state_q == S_ISSUE) ? grant_q : '0;
  // Done pulses in the same cycle as the last pending bit count, so XFER can
  // leave immediately instead of one cycle later.
  assign pending_left = pending & ~xfer_done;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|live_req) state_d = S_REQ;
      S_REQ:   if (arb_ready_in) state_d = S_WAIT;
      S_WAIT:  if (arb_valid_in) state_d = (|grant_clean) ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = S_XFER;
      S_XFER:  if (pending_left == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  assign arb_valid_out = (state_q == S_REQ);
  assign arb_ready_out = (state_q == S_WAIT);
  assign busy          = (state_q != S_IDLE);
  assign xfer_start    = (state_q == S_ISSUE) ? row_any : '0;
  assign state_dbg     = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_vect  <= '0;
      grant_q   <= '0;
      xfer_sel  <= '0;
      pending   <= '0;
      voq_ovf   <= 1'b0;
      grant_err <= 1'b0;
      cnt       <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (|live_req) req_vect <= live_req;
        end
        S_WAIT: begin
          if (arb_valid_in) begin
            grant_q  <= grant_clean;
            xfer_sel <= sel_d;
            if (grant_bad) grant_err <= 1'b1;
            if (grant_clean == '0) req_vect <= '0;
          end
        end
        S_ISSUE: begin
          pending <= row_any;
        end
        S_XFER: begin
          pending <= pending_left;
          if (pending_left == '0) req_vect <= '0;
        end
        default: ;
      endcase
      // Same-cycle enqueue and dequeue of one pair cancel out.
      for (int k = 0; k < N; k++) begin
        if (voq_enq[k] && !dec_vec[k]) begin
          if (cnt[k] == CNT_MAX) voq_ovf <= 1'b1;
          else                   cnt[k] <= cnt[k] + CNT_ONE;
        end else if (dec_vec[k] && !voq_enq[k] && (cnt[k] != '0)) begin
          cnt[k] <= cnt[k] - CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_islip_voq_sched.sv
// tb_islip_voq_sched
//   Directed bench for islip_voq_sched (PORTS=4, CNT_WIDTH=8). The bench acts
//   as the arbiter and the crossbar. Inputs change and outputs are sampled on
//   the falling clock edge.
module tb_islip_voq_sched;

  logic        clk;
  logic        rst;
  logic [15:0] voq_enq;
  logic [3:0]  tx_rdy;
  logic        arb_valid_out;
  logic        arb_ready_in;
  logic [15:0] req_vect;
  logic        arb_valid_in;
  logic        arb_ready_out;
  logic [15:0] grant_vect;
  logic [3:0]  xfer_start;
  logic [7:0]  xfer_sel;
  logic [3:0]  xfer_done;
  logic        busy;
  logic        voq_ovf;
  logic        grant_err;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  islip_voq_sched #(.PORTS(4), .PORTS_L2(2), .CNT_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .voq_enq       (voq_enq),
    .tx_rdy        (tx_rdy),
    .arb_valid_out (arb_valid_out),
    .arb_ready_in  (arb_ready_in),
    .req_vect      (req_vect),
    .arb_valid_in  (arb_valid_in),
    .arb_ready_out (arb_ready_out),
    .grant_vect    (grant_vect),
    .xfer_start    (xfer_start),
    .xfer_sel      (xfer_sel),
    .xfer_done     (xfer_done),
    .busy          (busy),
    .voq_ovf       (voq_ovf),
    .grant_err     (grant_err),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic enq_pulse(input logic [15:0] mask);
    voq_enq = mask;
    tick();
    voq_enq = '0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!arb_valid_out && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid"}, 32'(arb_valid_out), 32'd1);
  endtask

  // One arbitration round: request handshake, grant, ISSUE checks, XFER.
  // With finish set, the granted transfers are completed and busy must drop.
  task automatic run_round(input string tag, input logic [15:0] exp_req,
                           input logic [15:0] grant, input logic [3:0] exp_start,
                           input logic [7:0] exp_sel, input bit finish);
    wait_valid(tag);
    check_eq({tag, "_req"}, 32'(req_vect), 32'(exp_req));
    arb_ready_in = 1'b1;
    tick();
    arb_ready_in = 1'b0;
    check_eq({tag, "_rdy_out"}, 32'(arb_ready_out), 32'd1);
    arb_valid_in = 1'b1;
    grant_vect   = grant;
    tick();
    arb_valid_in = 1'b0;
    grant_vect   = '0;
    check_eq({tag, "_start"}, 32'(xfer_start), 32'(exp_start));
    check_eq({tag, "_sel"}, 32'(xfer_sel), 32'(exp_sel));
    tick();
    check_eq({tag, "_start_off"}, 32'(xfer_start), 32'd0);
    check_eq({tag, "_busy_xfer"}, 32'(busy), 32'd1);
    if (finish) begin
      xfer_done = exp_start;
      tick();
      xfer_done = '0;
      check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; voq_enq = '0; tx_rdy = '0; arb_ready_in = 1'b0;
    arb_valid_in = 1'b0; grant_vect = '0; xfer_done = '0;
    tick();
    do_reset();

    // Reset state
    check_eq("rst_valid", 32'(arb_valid_out), 32'd0);
    check_eq("rst_rdy", 32'(arb_ready_out), 32'd0);
    check_eq("rst_req", 32'(req_vect), 32'd0);
    check_eq("rst_start", 32'(xfer_start), 32'd0);
    check_eq("rst_sel", 32'(xfer_sel), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ovf", 32'(voq_ovf), 32'd0);
    check_eq("rst_gerr", 32'(grant_err), 32'd0);
    check_eq("rst_cnt6", 32'(dut.cnt[6]), 32'd0);

    // Single pair in1 -> out2, with stall on both handshakes
    tx_rdy = 4'hF;
    enq_pulse(16'h0040);
    check_eq("sp_cnt_vis", 32'(dut.cnt[6]), 32'd1);
    check_eq("sp_not_yet", 32'(arb_valid_out), 32'd0);
    tick();
    check_eq("sp_valid_t2", 32'(arb_valid_out), 32'd1);
    check_eq("sp_req", 32'(req_vect), 32'h0040);
    tx_rdy = 4'h0;
    tick();
    check_eq("sp_valid_hold", 32'(arb_valid_out), 32'd1);
    check_eq("sp_req_hold", 32'(req_vect), 32'h0040);
    tx_rdy = 4'hF;
    arb_ready_in = 1'b1;
    tick();
    arb_ready_in = 1'b0;
    check_eq("sp_wait_rdy", 32'(arb_ready_out), 32'd1);
    check_eq("sp_wait_valid", 32'(arb_valid_out), 32'd0);
    tick();
    check_eq("sp_wait_rdy2", 32'(arb_ready_out), 32'd1);
    arb_valid_in = 1'b1;
    grant_vect   = 16'h0040;
    tick();
    arb_valid_in = 1'b0;
    grant_vect   = '0;
    check_eq("sp_start", 32'(xfer_start), 32'b0010);
    check_eq("sp_sel", 32'(xfer_sel), 32'h08);
    check_eq("sp_cnt_issue", 32'(dut.cnt[6]), 32'd1);
    xfer_done = 4'b0010;  // during ISSUE: must be ignored
    tick();
    xfer_done = '0;
    check_eq("sp_busy_xfer", 32'(busy), 32'd1);
    check_eq("sp_cnt_after", 32'(dut.cnt[6]), 32'd0);
    xfer_done = 4'b0001;  // not pending: ignored
    tick();
    xfer_done = '0;
    check_eq("sp_busy_stray", 32'(busy), 32'd1);
    xfer_done = 4'b0010;
    tick();
    xfer_done = '0;
    check_eq("sp_busy_end", 32'(busy), 32'd0);
    check_eq("sp_req_clr", 32'(req_vect), 32'd0);
    repeat (4) tick();
    check_eq("sp_no_rereq", 32'(arb_valid_out), 32'd0);

    // Contention on out3
    enq_pulse(16'h0088);
    run_round("cont0", 16'h0088, 16'h0008, 4'b0001, 8'h0B, 1'b1);
    check_eq("cont_cnt7", 32'(dut.cnt[7]), 32'd1);
    run_round("cont1", 16'h0080, 16'h0080, 4'b0010, 8'h0F, 1'b1);

    // Backpressure on out1
    tx_rdy = 4'b1101;
    enq_pulse(16'h0200);
    repeat (3) tick();
    check_eq("bp_valid_low", 32'(arb_valid_out), 32'd0);
    check_eq("bp_busy_low", 32'(busy), 32'd0);
    tx_rdy = 4'hF;
    run_round("bp", 16'h0200, 16'h0200, 4'b0100, 8'h1F, 1'b1);

    // Saturation of in0 -> out0
    tx_rdy  = 4'h0;
    voq_enq = 16'h0001;
    repeat (255) tick();
    check_eq("sat_cnt255", 32'(dut.cnt[0]), 32'd255);
    check_eq("sat_ovf_pre", 32'(voq_ovf), 32'd0);
    tick();
    voq_enq = '0;
    check_eq("sat_cnt_hold", 32'(dut.cnt[0]), 32'd255);
    check_eq("sat_ovf", 32'(voq_ovf), 32'd1);
    tx_rdy = 4'hF;
    run_round("sat", 16'h0001, 16'h0001, 4'b0001, 8'h1C, 1'b1);
    check_eq("sat_cnt254", 32'(dut.cnt[0]), 32'd254);
    do_reset();
    check_eq("sat_rst_cnt", 32'(dut.cnt[0]), 32'd0);
    check_eq("sat_rst_ovf", 32'(voq_ovf), 32'd0);

    // All-zero grant, then multi-bit grant row
    enq_pulse(16'h0030);
    wait_valid("zg");
    check_eq("zg_req", 32'(req_vect), 32'h0030);
    arb_ready_in = 1'b1;
    tick();
    arb_ready_in = 1'b0;
    arb_valid_in = 1'b1;
    grant_vect   = 16'h0000;
    tick();
    arb_valid_in = 1'b0;
    check_eq("zg_busy", 32'(busy), 32'd0);
    check_eq("zg_req_clr", 32'(req_vect), 32'd0);
    check_eq("zg_cnt4", 32'(dut.cnt[4]), 32'd1);
    check_eq("zg_cnt5", 32'(dut.cnt[5]), 32'd1);
    check_eq("zg_gerr", 32'(grant_err), 32'd0);
    run_round("multi", 16'h0030, 16'h0030, 4'b0010, 8'h00, 1'b1);
    check_eq("multi_gerr", 32'(grant_err), 32'd1);
    check_eq("multi_cnt4", 32'(dut.cnt[4]), 32'd0);
    check_eq("multi_cnt5", 32'(dut.cnt[5]), 32'd1);
    do_reset();
    check_eq("multi_rst_gerr", 32'(grant_err), 32'd0);

    // Grant bit outside the request
    enq_pulse(16'h0020);
    run_round("outside", 16'h0020, 16'h0021, 4'b0010, 8'h04, 1'b1);
    check_eq("outside_gerr", 32'(grant_err), 32'd1);
    check_eq("outside_cnt5", 32'(dut.cnt[5]), 32'd0);

    // Reset with two transfers pending
    enq_pulse(16'h0021);
    run_round("mid", 16'h0021, 16'h0021, 4'b0011, 8'h04, 1'b0);
    enq_pulse(16'h0021);
    check_eq("mid_cnt0_pre", 32'(dut.cnt[0]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_sel", 32'(xfer_sel), 32'd0);
    check_eq("mid_cnt0", 32'(dut.cnt[0]), 32'd0);
    check_eq("mid_cnt5", 32'(dut.cnt[5]), 32'd0);
    check_eq("mid_gerr", 32'(grant_err), 32'd0);
    xfer_done = 4'b0011;
    tick();
    xfer_done = '0;
    repeat (3) tick();
    check_eq("mid_busy_late", 32'(busy), 32'd0);
    check_eq("mid_valid_late", 32'(arb_valid_out), 32'd0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
